mem_slave_resp: RTL and testbench

//  Memory-backed responder for one crossbar slave port (slave_N_*); the target end of the
//  req/cmd/addr/wdata -> ack/rdata protocol the crossbar drives. Holds 2**ADDR_W 32-bit words.
//  Ack latency is programmable, with optional pseudo-random extra wait cycles to stress

---
 rtl/mem_slave_resp.sv | 78 +++++++
 tb/tb_mem_slave_resp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_slave_resp.sv
// mem_slave_resp: memory-backed crossbar slave with programmable, optionally randomised ack latency
module mem_slave_resp #(
  parameter int         ADDR_W    = 4,
  parameter int         ACK_LAT   = 2,
  parameter bit         RAND_LAT  = 1'b0,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        cmd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RDATA} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, lat;
  logic [7:0] lfsr_q, lfsr_d;
  logic cmd_q, cmd_d, take;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] mem_d [2**ADDR_W];
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign lat = 5'(ACK_LAT) + (RAND_LAT ? {3'b0, lfsr_q[1:0]} : 5'd0);
  assign take = state_q == IDLE && req;
  // State and datapath registers; reset drops any in-flight transaction and clears the RAM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end
  // Next state: requests are only sampled in IDLE, latency counted down in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = lat > 5'd1 ? WAIT : ACK;
      WAIT:    if (cnt_q == 5'd1) state_d = ACK;
      ACK:     state_d = cmd_q ? IDLE : RDATA;
      default: state_d = IDLE;
    endcase
  end
  // Datapath: latch the request, count latency, commit writes and fetch reads on the ack edge
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cmd_d   = take ? cmd : cmd_q;
    idx_d   = take ? addr[ADDR_W+1:2] : idx_q;
    wdata_d = take ? wdata : wdata_q;
    cnt_d   = take ? lat - 5'd1 : (state_q == WAIT ? cnt_q - 5'd1 : cnt_q);
    rdata_d = state_q == ACK && !cmd_q ? mem_q[idx_q] : 32'h0;
    mem_d   = mem_q;
    if (state_q == ACK && cmd_q) mem_d[idx_q] = wdata_q;
  end
  // Outputs: rdata_q is only non-zero in RDATA, so the crossbar can OR slaves together
  always_comb begin
    ack   = state_q == ACK;
    rdata = rdata_q;
  end
endmodule

// File: tb/tb_mem_slave_resp.sv
// tb_mem_slave_resp: directed and randomised checks of mem_slave_resp against a timing/memory model
module tb_mem_slave_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, cmd = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic ack;
  logic [31:0] rdata;
  logic req2 = 1'b0, cmd2 = 1'b0;
  logic [31:0] addr2 = '0, wdata2 = '0;
  logic ack2;
  logic [31:0] rdata2;
  int errors = 0, checks = 0, cyc = 0;
  bit done = 1'b0;

  mem_slave_resp #(.ADDR_W(4), .ACK_LAT(2), .RAND_LAT(1'b0), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(rst_n), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata));

  mem_slave_resp #(.ADDR_W(4), .ACK_LAT(2), .RAND_LAT(1'b1), .LFSR_SEED(8'hA5)) dut2 (
    .clk(clk), .reset(rst_n), .req(req2), .cmd(cmd2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .rdata(rdata2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model of the fixed-latency instance (L=2): a request seen at edge n while free acks in
  // cycle n+L, returns data in cycle n+L+1, and frees the slave at edge n+L+1 (write) or n+L+2 (read).
  logic [31:0] mem_m [16];
  int ack_at = -1, rd_at = -1, free_at = 0;
  logic [31:0] rd_val = '0, wr_val = '0;
  logic [3:0] wr_idx = '0;
  bit wr_pend = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (mem_m[i]) mem_m[i] <= '0;
      ack_at  <= -1;
      rd_at   <= -1;
      free_at <= 0;
      wr_pend <= 1'b0;
    end else begin
      if (wr_pend && cyc == ack_at) begin
        mem_m[wr_idx] <= wr_val;
        wr_pend <= 1'b0;
      end
      if (req && cyc >= free_at) begin
        ack_at  <= cyc + 2;
        free_at <= cyc + (cmd ? 3 : 4);
        if (cmd) begin
          wr_pend <= 1'b1;
          wr_idx  <= addr[5:2];
          wr_val  <= wdata;
        end else begin
          rd_at  <= cyc + 3;
          rd_val <= mem_m[addr[5:2]];
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the fixed-latency instance against the model
  always @(negedge clk) begin
    if (!done) begin
      chk("ack", {31'b0, ack}, {31'b0, cyc == ack_at});
      chk("rdata", rdata, cyc == rd_at ? rd_val : 32'h0);
    end
  end

  task automatic xact(input logic c, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; cmd = c; addr = a; wdata = d;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (ack) lat = k;
    end
    req = 1'b0;
    if (lat == 0) begin
      errors++;
      $display("FAIL ack_timeout: no ack for addr %h", a);
    end
    @(negedge clk);
    rd = rdata;
  endtask

  int lat, c1, c2;
  logic [31:0] rd;
  logic [31:0] ref2 [16];

  initial begin
    foreach (ref2[i]) ref2[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'b0, ack}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ack2", {31'b0, ack2}, 32'h0);
    rst_n = 1'b1;
    // read straight after reset, then write/read round trip
    xact(1'b0, 32'h0000_0004, 32'h0, lat, rd);
    chk("t2_lat", lat, 2);
    chk("t2_rdata", rd, 32'h0);
    xact(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, lat, rd);
    chk("t1_wlat", lat, 2);
    chk("t1_w_rdata", rd, 32'h0);
    xact(1'b0, 32'h0000_0008, 32'h0, lat, rd);
    chk("t1_rlat", lat, 2);
    chk("t1_rdata", rd, 32'hDEAD_BEEF);
    // aliasing: addr[31] ignored, index wraps
    xact(1'b1, 32'h8000_0040, 32'h1234_5678, lat, rd);
    xact(1'b0, 32'h0000_0000, 32'h0, lat, rd);
    chk("t3_rdata", rd, 32'h1234_5678);
    xact(1'b1, 32'h0000_003C, 32'hA5A5_5A5A, lat, rd);
    xact(1'b0, 32'hFFFF_FFFF, 32'h0, lat, rd);
    chk("alias15_rdata", rd, 32'hA5A5_5A5A);
    // req held high: write then read back-to-back
    @(negedge clk);
    req = 1'b1; cmd = 1'b1; addr = 32'h14; wdata = 32'h0BAD_C0DE;
    c1 = -1; c2 = -1;
    for (int k = 0; k < 20 && c2 < 0; k++) begin
      @(negedge clk);
      if (ack) begin
        if (c1 < 0) begin
          c1 = cyc; cmd = 1'b0; wdata = 32'hFFFF_FFFF;
        end else begin
          c2 = cyc; req = 1'b0;
        end
      end
    end
    req = 1'b0;
    chk("t4_gap", 32'(c2 - c1), 32'd3);
    @(negedge clk);
    chk("t4_rdata", rdata, 32'h0BAD_C0DE);
    // reset while waiting drops the write
    @(negedge clk);
    req = 1'b1; cmd = 1'b1; addr = 32'h18; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_ack", {31'b0, ack}, 32'h0);
    end
    xact(1'b0, 32'h18, 32'h0, lat, rd);
    chk("t5_lat", lat, 2);
    chk("t5_rdata", rd, 32'h0);
    // randomised latency instance against a reference memory
    for (int t = 0; t < 200; t++) begin
      logic c;
      logic [31:0] a, d;
      c = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      @(negedge clk);
      req2 = 1'b1; cmd2 = c; addr2 = a; wdata2 = d;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        @(negedge clk);
        if (ack2) lat = k;
      end
      req2 = 1'b0;
      checks++;
      if (lat < 2 || lat > 5) begin
        errors++;
        $display("FAIL rand_lat: got %0d expected 2..5 (txn %0d)", lat, t);
      end
      @(negedge clk);
      chk("rand_ack_width", {31'b0, ack2}, 32'h0);
      if (c) begin
        chk("rand_w_rdata", rdata2, 32'h0);
        ref2[a[5:2]] = d;
      end else begin
        chk("rand_rdata", rdata2, ref2[a[5:2]]);
      end
    end
    @(negedge clk);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
